// File: rtl/freq_gate_seq_pkg.sv
// Shared types and helpers for the frequency-meter gate sequencer.
// Imported by the interface, the gate timer and the sequencer top.
package freq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_GATE  = 3'd2,
        ST_LATCH = 3'd3,
        ST_EVAL  = 3'd4
    } fg_state_t;

    typedef enum logic [1:0] {
        DEC_FINAL = 2'd0,
        DEC_DOWN  = 2'd1,
        DEC_UP    = 2'd2
    } fg_dec_t;

    typedef logic [1:0] range_t;

    localparam logic [1:0] MAX_RETRY = 2'd3;
    localparam range_t     RANGE_MAX = 2'd3;

    function automatic logic [31:0] gate_len(input logic [31:0] base, input range_t r);
        logic [31:0] len_s;
        case (r)
            2'd0:    len_s = base;
            2'd1:    len_s = base * 32'd10;
            2'd2:    len_s = base * 32'd100;
            default: len_s = base * 32'd1000;
        endcase
        return len_s;
    endfunction

endpackage

// File: rtl/freq_gate_seq_if.sv
// Control/datapath bundle between host, sequencer and counter datapath.
// master = host/datapath side, slave = sequencer side.
interface freq_gate_seq_if;
    import freq_pkg::*;

    logic   start;
    logic   cont;
    logic   auto;
    range_t range_in;
    logic   cnt_ovf;
    logic   cnt_low;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_latch;
    logic   busy;
    logic   done;
    range_t range;
    logic   ovf_err;

    modport master (
        output start, cont, auto, range_in, cnt_ovf, cnt_low,
        input  cnt_clr, cnt_en, cnt_latch, busy, done, range, ovf_err
    );

    modport slave (
        input  start, cont, auto, range_in, cnt_ovf, cnt_low,
        output cnt_clr, cnt_en, cnt_latch, busy, done, range, ovf_err
    );

endinterface

// File: rtl/freq_gate_seq_gate_timer.sv
// Loadable gate down-counter; expire flags the last cycle of a running gate.
module gate_timer
    import freq_pkg::*;
#(
    parameter int GATE_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              run,
    input  logic [GATE_W-1:0] len,
    output logic              expire
);

    localparam logic [GATE_W-1:0] ONE_C  = {{(GATE_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_W-1:0] ZERO_C = {GATE_W{1'b0}};

    logic [GATE_W-1:0] count_r;

    // Count register: loaded once per attempt, stepped down while the gate runs
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_C;
        end else if (load) begin
            count_r <= len;
        end else if (run && (count_r != ZERO_C)) begin
            count_r <= count_r - ONE_C;
        end
    end

    assign expire = run && (count_r == ONE_C);

endmodule

// File: rtl/freq_gate_seq.sv
// Gate-window sequencer: clear/enable/latch strobes, decade ranging and auto-range retries.
// All outputs are flops fed from the next-state decode.
module freq_gate_seq
    import freq_pkg::*;
#(
    parameter int GATE_BASE = 1000,
    parameter int GATE_W    = 24
) (
    input logic            clk,
    input logic            reset,
    freq_gate_seq_if.slave bus
);

    fg_state_t   state_r;
    fg_state_t   state_nxt_s;
    fg_dec_t     dec_s;
    fg_dec_t     dec_r;
    range_t      range_r;
    logic [1:0]  retry_r;
    logic        ovf_r;
    logic        expire_s;
    logic        go_s;

    logic        cnt_clr_r;
    logic        cnt_en_r;
    logic        cnt_latch_r;
    logic        busy_r;
    logic        done_r;
    range_t      range_out_r;
    logic        ovf_err_r;

    gate_timer #(.GATE_W(GATE_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (state_r == ST_CLEAR),
        .run    (state_r == ST_GATE),
        .len    (GATE_W'(gate_len(32'(GATE_BASE), range_r))),
        .expire (expire_s)
    );

    assign go_s = bus.start || bus.cont;

    // Range decision, taken in LATCH and registered so done can be a flop during EVAL
    always_comb begin
        dec_s = DEC_FINAL;
        if (bus.auto && ovf_r && (range_r != 2'd0) && (retry_r < MAX_RETRY)) begin
            dec_s = DEC_DOWN;
        end else if (bus.auto && bus.cnt_low && !ovf_r && (range_r < RANGE_MAX)
                     && (retry_r < MAX_RETRY)) begin
            dec_s = DEC_UP;
        end else begin
            dec_s = DEC_FINAL;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go_s) state_nxt_s = ST_CLEAR;
                else      state_nxt_s = ST_IDLE;
            end
            ST_CLEAR: state_nxt_s = ST_GATE;
            ST_GATE: begin
                if (expire_s) state_nxt_s = ST_LATCH;
                else          state_nxt_s = ST_GATE;
            end
            ST_LATCH: state_nxt_s = ST_EVAL;
            ST_EVAL: begin
                if ((dec_r != DEC_FINAL) || bus.cont) state_nxt_s = ST_CLEAR;
                else                                  state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Working range, retry count, ovf latch and the registered decision
    always_ff @(posedge clk) begin
        if (reset) begin
            range_r <= 2'd0;
            retry_r <= 2'd0;
            ovf_r   <= 1'b0;
            dec_r   <= DEC_FINAL;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        if (!bus.auto) range_r <= bus.range_in;
                        retry_r <= 2'd0;
                        ovf_r   <= 1'b0;
                    end
                end
                ST_CLEAR: ovf_r <= 1'b0;
                ST_GATE:  ovf_r <= ovf_r | bus.cnt_ovf;
                ST_LATCH: dec_r <= dec_s;
                ST_EVAL: begin
                    case (dec_r)
                        DEC_DOWN: begin
                            range_r <= range_r - 2'd1;
                            retry_r <= retry_r + 2'd1;
                        end
                        DEC_UP: begin
                            range_r <= range_r + 2'd1;
                            retry_r <= retry_r + 2'd1;
                        end
                        default: retry_r <= 2'd0;
                    endcase
                end
                default: ovf_r <= 1'b0;
            endcase
        end
    end

    // Output registers; strobes follow the state about to be entered
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_clr_r   <= 1'b0;
            cnt_en_r    <= 1'b0;
            cnt_latch_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            range_out_r <= 2'd0;
            ovf_err_r   <= 1'b0;
        end else begin
            cnt_clr_r   <= (state_nxt_s == ST_CLEAR);
            cnt_en_r    <= (state_nxt_s == ST_GATE);
            cnt_latch_r <= (state_nxt_s == ST_LATCH);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_r == ST_LATCH) && (dec_s == DEC_FINAL);
            if ((state_r == ST_LATCH) && (dec_s == DEC_FINAL)) begin
                range_out_r <= range_r;
                ovf_err_r   <= ovf_r;
            end
        end
    end

    assign bus.cnt_clr   = cnt_clr_r;
    assign bus.cnt_en    = cnt_en_r;
    assign bus.cnt_latch = cnt_latch_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.range     = range_out_r;
    assign bus.ovf_err   = ovf_err_r;

endmodule

// File: tb/tb_freq_gate_seq.sv
// Self-checking bench for freq_gate_seq with GATE_BASE=4 (gates of 4/40/400/4000 cycles).
// A measurement-level model predicts every output each cycle; a negedge process compares.
module tb_freq_gate_seq;
    import freq_pkg::*;

    localparam int BASE = 4;

    logic clk = 1'b0;
    logic reset;
    freq_gate_seq_if bus();

    freq_gate_seq #(.GATE_BASE(BASE), .GATE_W(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_chk = 0;
    int   n_pass = 0;
    bit   chk_on = 1'b0;
    logic e_clr, e_en, e_lat, e_busy, e_done, e_oe;
    logic [1:0] e_rng;
    int   m_range = 0;
    int   t_start = 0;
    int   m_done_off = -1;
    int   dut_done_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cnt_clr",   {31'd0, bus.cnt_clr},   {31'd0, e_clr});
            chk("cnt_en",    {31'd0, bus.cnt_en},    {31'd0, e_en});
            chk("cnt_latch", {31'd0, bus.cnt_latch}, {31'd0, e_lat});
            chk("busy",      {31'd0, bus.busy},      {31'd0, e_busy});
            chk("done",      {31'd0, bus.done},      {31'd0, e_done});
            chk("range",     {30'd0, bus.range},     {30'd0, e_rng});
            chk("ovf_err",   {31'd0, bus.ovf_err},   {31'd0, e_oe});
            if (bus.done === 1'b1) dut_done_cyc = cyc;
        end
    end

    // Advance one clock and publish the expected outputs for the new cycle.
    task automatic step(input bit clr, input bit en, input bit lat, input bit bsy, input bit dn,
                        input bit upd, input int rng, input bit oe);
        @(posedge clk); #1;
        e_clr = clr; e_en = en; e_lat = lat; e_busy = bsy; e_done = dn;
        if (upd) begin
            e_rng = rng[1:0];
            e_oe  = oe;
        end
    endtask

    function automatic bit noise();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // One session: start, `runs` results (continuous when runs>1), then back to idle.
    // ovf_mode: 0 none, 1 rare random, 2 every gate cycle, 3 single pulse in first gate.
    // low_mode: 0 never, 1 always, 2 random per attempt. kick: start pulses during gates.
    task automatic session(input bit a, input int rin, input int ovf_mode, input int low_mode,
                           input int runs, input bit kick);
        int  len, retries, att;
        bit  ovf_seen, low, v, down, up, final_d;
        bus.auto = a; bus.range_in = rin[1:0]; bus.start = 1'b1; bus.cont = (runs > 1);
        if (!a) m_range = rin;
        dut_done_cyc = -1;
        m_done_off = -1;
        for (int run = 1; run <= runs; run++) begin
            retries = 0; att = 0; final_d = 1'b0;
            while (!final_d) begin
                len = BASE;
                for (int p = 0; p < m_range; p++) len = len * 10;
                low = (low_mode == 1) || ((low_mode == 2) && ($urandom_range(0, 3) == 0));
                step(1, 0, 0, 1, 0, 0, 0, 0);
                if (run == 1 && att == 0) begin
                    t_start = cyc - 1;
                    bus.start = 1'b0;
                end
                bus.cnt_low = low;
                bus.cnt_ovf = noise();
                ovf_seen = 1'b0;
                for (int i = 0; i < len; i++) begin
                    step(0, 1, 0, 1, 0, 0, 0, 0);
                    v = (ovf_mode == 2) || ((ovf_mode == 1) && ($urandom_range(0, 31) == 0))
                        || ((ovf_mode == 3) && (run == 1) && (att == 0) && (i == 5));
                    bus.cnt_ovf = v;
                    ovf_seen |= v;
                    if (kick) bus.start = (i == 1);
                    bus.range_in = 2'($urandom_range(0, 3));
                    if (run == runs && att == 0 && i == 0) bus.cont = 1'b0;
                end
                step(0, 0, 1, 1, 0, 0, 0, 0);
                bus.cnt_ovf = noise();
                down = a && ovf_seen && (m_range > 0) && (retries < 3);
                up = !down && a && low && !ovf_seen && (m_range < 3) && (retries < 3);
                final_d = !down && !up;
                step(0, 0, 0, 1, final_d, final_d, m_range, ovf_seen);
                if (final_d) m_done_off = cyc - t_start;
                if (down) begin m_range--; retries++; end
                else if (up) begin m_range++; retries++; end
                att++;
            end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.cont = 1'b0; bus.auto = 1'b0; bus.range_in = 2'd0;
        bus.cnt_ovf = 1'b0; bus.cnt_low = 1'b0;
        e_clr = 1'b0; e_en = 1'b0; e_lat = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_oe = 1'b0; e_rng = 2'd0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Manual single shot at range 1
        session(0, 1, 0, 0, 1, 0);
        chk("t1_model_done", m_done_off, 43);
        chk("t1_dut_done", dut_done_cyc - t_start, 43);
        chk("t1_range", {30'd0, bus.range}, 1);

        // Auto down-range from sticky range 2 after a single overflow pulse
        session(0, 2, 0, 0, 1, 0);
        session(1, 0, 3, 0, 1, 0);
        chk("t2_model_done", m_done_off, 446);
        chk("t2_dut_done", dut_done_cyc - t_start, 446);
        chk("t2_range", {30'd0, bus.range}, 1);

        // Overflow at the floor, manual then auto (cnt_low also set: ovf wins)
        session(0, 0, 2, 0, 1, 0);
        chk("t3_manual_ovf_err", {31'd0, bus.ovf_err}, 1);
        session(1, 0, 2, 1, 1, 0);
        chk("t3_model_done", m_done_off, 7);
        chk("t3_dut_done", dut_done_cyc - t_start, 7);
        chk("t3_ovf_err", {31'd0, bus.ovf_err}, 1);

        // Retry limit from range 0, then from range 1
        session(1, 0, 0, 1, 1, 0);
        chk("t4a_model_done", m_done_off, 4456);
        chk("t4a_dut_done", dut_done_cyc - t_start, 4456);
        chk("t4a_range", {30'd0, bus.range}, 3);
        session(0, 1, 0, 0, 1, 0);
        session(1, 0, 0, 1, 1, 0);
        chk("t4b_dut_done", dut_done_cyc - t_start, 4449);
        chk("t4b_range", {30'd0, bus.range}, 3);

        // Continuous mode, ignored start pulses, cont dropped mid-gate
        session(0, 0, 1, 0, 3, 1);
        chk("t5_dut_last_done", dut_done_cyc - t_start, 21);
        session(1, 0, 1, 2, 2, 1);

        // Reset in the middle of a gate
        bus.auto = 1'b0; bus.range_in = 2'd1; bus.start = 1'b1;
        step(1, 0, 0, 1, 0, 0, 0, 0);
        bus.start = 1'b0; bus.cnt_low = 1'b0; bus.cnt_ovf = 1'b0;
        for (int i = 0; i < 10; i++) step(0, 1, 0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 1, 0, 0);
        reset = 1'b0;
        m_range = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        session(0, 1, 0, 0, 1, 0);
        chk("t6_dut_done", dut_done_cyc - t_start, 43);

        // Randomized sessions
        for (int k = 0; k < 10; k++) begin
            bit a;
            a = 1'($urandom_range(0, 1));
            if (m_range == 3) a = 1'b0;
            session(a, $urandom_range(0, 1), $urandom_range(0, 3), 2 * $urandom_range(0, 1),
                    $urandom_range(1, 2), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
